// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe turn sequencer: debounced select -> validate -> write -> 8-line scan -> result.
// Result or player toggle 11 cycles after the press event; presses while busy or game over are dropped.
module ttt_turn_controller #(
  parameter int CLK_HZ           = 50000000,
  parameter int POLL_HZ          = 1000,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic        MAX10_CLK1_50,
  input  logic        rst,
  input  logic        select_n,
  input  logic [8:0]  move,
  input  logic        new_game,
  output logic [17:0] board,
  output logic        player,
  output logic        busy,
  output logic        game_over,
  output logic        p1_win,
  output logic        p2_win,
  output logic        tie,
  output logic        invalid
);

  localparam int TICK_DIV = CLK_HZ / POLL_HZ;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(DEBOUNCE_SAMPLES + 1);

  typedef enum logic [2:0] {IDLE, VALIDATE, WRITE, SCAN, RESULT, DONE} state_t;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          sel_meta;
  logic          sel_sync;
  logic          key_down;
  logic [SW-1:0] smp_cnt;
  logic          press_evt;

  state_t        state;
  logic [8:0]    move_q;
  logic [2:0]    line_idx;
  logic [1:0]    winner;
  logic [4:0]    pa, pb, pc;
  logic [1:0]    ca, cb, cc;
  logic [1:0]    line_code;
  logic [1:0]    win_next;
  logic          board_full;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Counts consecutive tick samples that disagree with the accepted key state.
  always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
    if (!rst) begin
      sel_meta  <= 1'b1;
      sel_sync  <= 1'b1;
      key_down  <= 1'b0;
      smp_cnt   <= '0;
      press_evt <= 1'b0;
    end else begin
      sel_meta  <= select_n;
      sel_sync  <= sel_meta;
      press_evt <= 1'b0;
      if (tick) begin
        if ((!sel_sync) != key_down) begin
          if (smp_cnt == SW'(DEBOUNCE_SAMPLES - 1)) begin
            key_down  <= ~key_down;
            smp_cnt   <= '0;
            press_evt <= ~key_down;
          end else begin
            smp_cnt <= smp_cnt + SW'(1);
          end
        end else begin
          smp_cnt <= '0;
        end
      end
    end
  end

  function automatic logic move_ok(input logic [8:0] mv, input logic [17:0] b);
    logic occupied;
    occupied = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (mv[i] && (b[2*i +: 2] != 2'b00)) occupied = 1'b1;
    end
    return (mv != 9'd0) && ((mv & (mv - 9'd1)) == 9'd0) && !occupied;
  endfunction

  // Bit offsets of the three cells on the line currently being scanned.
  always_comb begin
    pa = 5'd0;
    pb = 5'd2;
    pc = 5'd4;
    case (line_idx)
      3'd0: begin pa = 5'd0;  pb = 5'd2;  pc = 5'd4;  end
      3'd1: begin pa = 5'd6;  pb = 5'd8;  pc = 5'd10; end
      3'd2: begin pa = 5'd12; pb = 5'd14; pc = 5'd16; end
      3'd3: begin pa = 5'd0;  pb = 5'd6;  pc = 5'd12; end
      3'd4: begin pa = 5'd2;  pb = 5'd8;  pc = 5'd14; end
      3'd5: begin pa = 5'd4;  pb = 5'd10; pc = 5'd16; end
      3'd6: begin pa = 5'd0;  pb = 5'd8;  pc = 5'd16; end
      default: begin pa = 5'd4; pb = 5'd8; pc = 5'd12; end
    endcase
  end

  always_comb begin
    ca         = board[pa +: 2];
    cb         = board[pb +: 2];
    cc         = board[pc +: 2];
    line_code  = ((ca != 2'b00) && (ca == cb) && (cb == cc)) ? ca : 2'b00;
    win_next   = (winner != 2'b00) ? winner : line_code;
    board_full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (board[2*i +: 2] == 2'b00) board_full = 1'b0;
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      board     <= '0;
      player    <= 1'b0;
      busy      <= 1'b0;
      game_over <= 1'b0;
      p1_win    <= 1'b0;
      p2_win    <= 1'b0;
      tie       <= 1'b0;
      invalid   <= 1'b0;
      move_q    <= '0;
      line_idx  <= '0;
      winner    <= '0;
    end else begin
      p1_win  <= 1'b0;
      p2_win  <= 1'b0;
      tie     <= 1'b0;
      invalid <= 1'b0;
      if (new_game) begin
        state     <= IDLE;
        board     <= '0;
        player    <= 1'b0;
        busy      <= 1'b0;
        game_over <= 1'b0;
        line_idx  <= '0;
        winner    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (press_evt) begin
              move_q  <= move;
              state   <= VALIDATE;
              busy    <= 1'b1;
              // Flagged on entry so the pulse coincides with the VALIDATE cycle.
              invalid <= !move_ok(move, board);
            end
          end
          VALIDATE: begin
            if (move_ok(move_q, board)) begin
              state <= WRITE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          WRITE: begin
            for (int i = 0; i < 9; i++) begin
              if (move_q[i]) board[2*i +: 2] <= player ? 2'b10 : 2'b01;
            end
            state    <= SCAN;
            line_idx <= '0;
            winner   <= '0;
          end
          SCAN: begin
            winner <= win_next;
            if (line_idx == 3'd7) begin
              state  <= RESULT;
              busy   <= 1'b0;
              p1_win <= (win_next == 2'b01);
              p2_win <= (win_next == 2'b10);
              tie    <= (win_next == 2'b00) && board_full;
            end else begin
              line_idx <= line_idx + 3'd1;
            end
          end
          RESULT: begin
            if ((winner != 2'b00) || board_full) begin
              state     <= DONE;
              game_over <= 1'b1;
            end else begin
              player <= ~player;
              state  <= IDLE;
            end
          end
          DONE: state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Bench for ttt_turn_controller: scripted game table, hand-written corner sequences, random moves vs model.
module tb_ttt_turn_controller;

  localparam int K_NONE = 0;
  localparam int K_INV  = 1;
  localparam int K_P1   = 2;
  localparam int K_P2   = 3;
  localparam int K_TIE  = 4;
  localparam int K_IGN  = 5;

  logic        clk;
  logic        rst;
  logic        select_n;
  logic [8:0]  move;
  logic        new_game;
  logic [17:0] board;
  logic        player;
  logic        busy;
  logic        game_over;
  logic        p1_win;
  logic        p2_win;
  logic        tie;
  logic        invalid;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        ng;
    logic [8:0]  mv;
    logic [17:0] eb;
    logic        ep;
    int          kind;
    logic        eo;
  } vec_t;

  vec_t vecs[17];

  int m_cell[9];
  int m_player;
  bit m_over;
  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  ttt_turn_controller #(.CLK_HZ(1000), .POLL_HZ(250), .DEBOUNCE_SAMPLES(2)) dut (
    .MAX10_CLK1_50(clk),
    .rst(rst),
    .select_n(select_n),
    .move(move),
    .new_game(new_game),
    .board(board),
    .player(player),
    .busy(busy),
    .game_over(game_over),
    .p1_win(p1_win),
    .p2_win(p2_win),
    .tie(tie),
    .invalid(invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] pulses();
    return {p1_win, p2_win, tie, invalid};
  endfunction

  function automatic logic [3:0] exp_pulse(input int kind);
    case (kind)
      K_P1:    return 4'b1000;
      K_P2:    return 4'b0100;
      K_TIE:   return 4'b0010;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) m_cell[i] = 0;
    m_player = 0;
    m_over   = 1'b0;
  endtask

  function automatic logic [17:0] model_board();
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_cell[i]);
    return b;
  endfunction

  task automatic model_apply(input logic [8:0] mv, output int kind);
    int c;
    bit full;
    kind = K_NONE;
    if (m_over) begin kind = K_IGN; return; end
    if ($countones(mv) != 1) begin kind = K_INV; return; end
    c = 0;
    for (int i = 0; i < 9; i++) if (mv[i]) c = i;
    if (m_cell[c] != 0) begin kind = K_INV; return; end
    m_cell[c] = m_player + 1;
    for (int l = 0; l < 8; l++) begin
      if (m_cell[lines[l][0]] != 0 && m_cell[lines[l][0]] == m_cell[lines[l][1]] &&
          m_cell[lines[l][1]] == m_cell[lines[l][2]]) begin
        kind   = (m_cell[lines[l][0]] == 1) ? K_P1 : K_P2;
        m_over = 1'b1;
        return;
      end
    end
    full = 1'b1;
    for (int i = 0; i < 9; i++) if (m_cell[i] == 0) full = 1'b0;
    if (full) begin kind = K_TIE; m_over = 1'b1; return; end
    m_player = 1 - m_player;
  endtask

  // Waits for the first cycle after the press event (busy or invalid rises).
  task automatic wait_v(output logic ok);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(busy || invalid) && t < 40);
    ok = busy || invalid;
    chk("press_accepted", 32'(ok), 32'd1);
  endtask

  task automatic release_key();
    logic seen;
    select_n = 1'b1;
    seen = 1'b0;
    repeat (24) begin
      @(negedge clk);
      if (busy || (pulses() != 4'b0)) seen = 1'b1;
    end
    chk("no_repeat_event", 32'(seen), 32'd0);
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    chk("ng_board", 32'(board), 32'd0);
    chk("ng_player", 32'(player), 32'd0);
    chk("ng_over", 32'(game_over), 32'd0);
  endtask

  task automatic run_move(input logic [8:0] mv, input logic [17:0] eb, input logic ep,
                          input int kind, input logic eo);
    logic ok;
    logic seen;
    int   busy_cnt;
    move     = mv;
    select_n = 1'b0;
    if (kind == K_IGN) begin
      seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (busy || (pulses() != 4'b0)) seen = 1'b1;
      end
      chk("ignored_activity", 32'(seen), 32'd0);
      chk("ignored_board", 32'(board), 32'(eb));
      chk("ignored_over", 32'(game_over), 32'd1);
    end else begin
      wait_v(ok);
      if (ok) begin
        if (kind == K_INV) begin
          chk("invalid_pulse", 32'(pulses()), 32'h1);
          @(negedge clk);
          chk("invalid_width", 32'(pulses()), 32'h0);
          chk("invalid_busy", 32'(busy), 32'd0);
          chk("invalid_board", 32'(board), 32'(eb));
          chk("invalid_player", 32'(player), 32'(ep));
        end else begin
          busy_cnt = 0;
          seen = 1'b0;
          for (int k = 0; k < 10; k++) begin
            if (busy) busy_cnt++;
            if (pulses() != 4'b0) seen = 1'b1;
            if (k == 2) chk("board_write", 32'(board), 32'(eb));
            @(negedge clk);
          end
          chk("busy_cycles", 32'(busy_cnt), 32'd10);
          chk("early_pulse", 32'(seen), 32'd0);
          chk("result_busy", 32'(busy), 32'd0);
          chk("result_pulse", 32'(pulses()), 32'(exp_pulse(kind)));
          @(negedge clk);
          chk("after_pulse", 32'(pulses()), 32'h0);
          chk("after_player", 32'(player), 32'(ep));
          chk("after_over", 32'(game_over), 32'(eo));
          chk("after_board", 32'(board), 32'(eb));
        end
      end
    end
    release_key();
  endtask

  initial begin
    logic ok;
    logic seen;
    int   kind;
    logic [8:0] mv;

    vecs[0]  = '{1'b0, 9'h001, 18'h00001, 1'b1, K_NONE, 1'b0};
    vecs[1]  = '{1'b0, 9'h003, 18'h00001, 1'b1, K_INV,  1'b0};
    vecs[2]  = '{1'b0, 9'h001, 18'h00001, 1'b1, K_INV,  1'b0};
    vecs[3]  = '{1'b0, 9'h002, 18'h00009, 1'b0, K_NONE, 1'b0};
    vecs[4]  = '{1'b0, 9'h010, 18'h00109, 1'b1, K_NONE, 1'b0};
    vecs[5]  = '{1'b0, 9'h004, 18'h00129, 1'b0, K_NONE, 1'b0};
    vecs[6]  = '{1'b0, 9'h100, 18'h10129, 1'b0, K_P1,   1'b1};
    vecs[7]  = '{1'b0, 9'h008, 18'h10129, 1'b0, K_IGN,  1'b1};
    vecs[8]  = '{1'b1, 9'h001, 18'h00001, 1'b1, K_NONE, 1'b0};
    vecs[9]  = '{1'b0, 9'h002, 18'h00009, 1'b0, K_NONE, 1'b0};
    vecs[10] = '{1'b0, 9'h004, 18'h00019, 1'b1, K_NONE, 1'b0};
    vecs[11] = '{1'b0, 9'h010, 18'h00219, 1'b0, K_NONE, 1'b0};
    vecs[12] = '{1'b0, 9'h008, 18'h00259, 1'b1, K_NONE, 1'b0};
    vecs[13] = '{1'b0, 9'h020, 18'h00A59, 1'b0, K_NONE, 1'b0};
    vecs[14] = '{1'b0, 9'h080, 18'h04A59, 1'b1, K_NONE, 1'b0};
    vecs[15] = '{1'b0, 9'h040, 18'h06A59, 1'b0, K_NONE, 1'b0};
    vecs[16] = '{1'b0, 9'h100, 18'h16A59, 1'b0, K_TIE,  1'b1};

    rst      = 1'b0;
    select_n = 1'b1;
    move     = 9'h000;
    new_game = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_board", 32'(board), 32'd0);
    chk("reset_player", 32'(player), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_over", 32'(game_over), 32'd0);
    chk("reset_pulses", 32'(pulses()), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // A low lasting one sample period must not register as a press.
    move     = 9'h001;
    select_n = 1'b0;
    repeat (4) @(negedge clk);
    select_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (busy || invalid) seen = 1'b1;
    end
    chk("glitch_no_press", 32'(seen), 32'd0);
    chk("glitch_board", 32'(board), 32'd0);

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].ng) do_new_game();
      run_move(vecs[i].mv, vecs[i].eb, vecs[i].ep, vecs[i].kind, vecs[i].eo);
    end

    // new_game during the scan aborts the turn with no result.
    do_new_game();
    move     = 9'h001;
    select_n = 1'b0;
    wait_v(ok);
    repeat (4) @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    chk("midscan_ng_board", 32'(board), 32'd0);
    chk("midscan_ng_player", 32'(player), 32'd0);
    chk("midscan_ng_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy || (pulses() != 4'b0)) seen = 1'b1;
    end
    chk("midscan_ng_quiet", 32'(seen), 32'd0);
    release_key();

    // Asynchronous reset during the scan.
    move     = 9'h010;
    select_n = 1'b0;
    wait_v(ok);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midscan_rst_board", 32'(board), 32'd0);
    chk("midscan_rst_busy", 32'(busy), 32'd0);
    chk("midscan_rst_player", 32'(player), 32'd0);
    chk("midscan_rst_pulses", 32'(pulses()), 32'd0);
    select_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy || (pulses() != 4'b0)) seen = 1'b1;
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);

    model_clear();
    for (int n = 0; n < 60; n++) begin
      if (m_over || ($urandom_range(0, 19) == 0)) begin
        do_new_game();
        model_clear();
      end
      if ($urandom_range(0, 9) < 8) mv = 9'h001 << $urandom_range(0, 8);
      else                          mv = 9'($urandom);
      model_apply(mv, kind);
      run_move(mv, model_board(), m_player[0], kind, m_over);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ttt_turn_controller.md
Name: ttt_turn_controller

Overview:
Sequences one tic-tac-toe game: debounces the select key, validates the one-hot switch move, writes the owning player's code into the board, then scans the 8 win lines one per clock.
Emits win/tie/invalid pulses for the score counters and drives the flattened board to the VGA controller.
Sits between the board switches/keys and the score/display logic, replacing ad-hoc frame-polled state handling.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
POLL_HZ, 1000, key sampling rate; tick period = CLK_HZ/POLL_HZ cycles
DEBOUNCE_SAMPLES, 4, consecutive equal samples required to accept a press or release

Ports:
MAX10_CLK1_50  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
select_n  input  1  raw select key, active-low, asynchronous to logic (2-flop synchronise)
move  input  9  switch move, must be one-hot, bit i = cell i (row-major 0..8)
new_game  input  1  synchronous clear-board request, level, active-high
board  output  18  board[2i+1:2i] = cell i: 00 empty, 01 player 1, 10 player 2, 11 never driven
player  output  1  side to move: 0 = player 1, 1 = player 2
busy  output  1  high in VALIDATE, WRITE, SCAN
game_over  output  1  high in DONE
p1_win  output  1  one-cycle pulse
p2_win  output  1  one-cycle pulse
tie  output  1  one-cycle pulse
invalid  output  1  one-cycle pulse on rejected move

Behaviour:
- Reset (rst low, async): board all 00, player 0, state IDLE, all pulses 0, busy 0, game_over 0, tick counter 0, debouncer in released state with sample count 0.
- Debouncer: tick every CLK_HZ/POLL_HZ cycles; the synchronised select_n is sampled on each tick. The pressed state is accepted after DEBOUNCE_SAMPLES consecutive low samples; the released state after DEBOUNCE_SAMPLES consecutive high samples. Accepting pressed generates press_evt for exactly one cycle; holding the key generates no further events.
- States: IDLE, VALIDATE, WRITE, SCAN, RESULT, DONE.
- IDLE: on press_evt, register move and go to VALIDATE.
- VALIDATE (1 cycle):
  - Valid means the registered move is exactly one-hot and the target cell is 00.
  - Valid -> WRITE.
  - Invalid -> IDLE with invalid=1 in that transition cycle; board and player unchanged.
- WRITE (1 cycle): cell = 01 if player==0, else 10. Go to SCAN with line index 0.
- SCAN (8 cycles, index 0..7): lines in order rows {0,1,2},{3,4,5},{6,7,8}; cols {0,3,6},{1,4,7},{2,5,8}; diags {0,4,8},{2,4,6}.
  - The first line with three equal non-zero cells latches the winner code.
  - Scanning continues to index 7 regardless, so latency is fixed.
- RESULT (1 cycle):
  - Winner 01 -> p1_win=1, go to DONE.
  - Winner 10 -> p2_win=1, go to DONE.
  - No winner and all 9 cells non-zero -> tie=1, go to DONE.
  - Otherwise toggle player, go to IDLE.
- Latency: press_evt in cycle P -> VALIDATE P+1, WRITE P+2 (board updates at end of P+2), SCAN P+3..P+10, result pulse or player toggle in P+11.
- DONE: press_evt ignored; board frozen; game_over=1.
- new_game: highest synchronous priority in any state, including mid-SCAN. Next cycle: board cleared, player 0, state IDLE, pulses 0. Debouncer state is untouched, so a key held across new_game makes no new press.
- press_evt while busy: dropped, never queued.
- Pulses are mutually exclusive; at most one is high in any cycle.

Test Plan:
Sim params CLK_HZ=1000, POLL_HZ=250 (tick every 4 cycles), DEBOUNCE_SAMPLES=2.

1. Reset, then press select with move=9'h001 -> VALIDATE, WRITE; board=18'h00001 at P+3; player=1 at P+12; no pulses; busy high exactly 10 cycles (P+1..P+10).
2. Glitch select_n low for 1 tick only -> no press_evt, board unchanged. Hold low 20 cycles -> exactly one move.
3. Invalid moves: move=9'h003 -> invalid pulse at P+1, board unchanged, player unchanged. Occupied cell 0 again -> invalid pulse.
4. P1 plays 0,4,8 interleaved with P2 at 1,2 -> p1_win pulse at P+11 of the 5th move; game_over=1; further presses leave board unchanged.
5. Full board with no line (P1:0,2,3,7,8; P2:1,4,5,6) -> tie pulse after the 9th move, and neither win pulse.
6. Assert new_game during SCAN (P+5) -> next cycle board=0, player=0, IDLE, no result pulse ever emitted. Assert rst mid-SCAN -> same state immediately, asynchronously.
